// File: rtl/overture_pkg.sv
// Shared definitions for the overture run controller: FSM state encoding,
// command opcodes and the CLEAR hold length.
package overture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_BREAK = 3'd3,
        ST_CLEAR = 3'd4
    } run_state_e;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam int CLEAR_CYCLES = 2;

endpackage

// File: rtl/overture_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones.
module overture_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/overture_run_ctrl.sv
// Run/step/breakpoint controller for a small CPU. Breakpoint support is built
// only when OVERTURE_RUN_CTRL_BREAKPOINT_EN is defined.
module overture_run_ctrl
    import overture_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_arg,
    input  logic             bp_en,
    input  logic [7:0]       bp_addr,
    input  logic [7:0]       cpu_pc,
    output logic             cpu_run,
    output logic             cpu_reset,
    output logic [2:0]       state,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    run_state_e state_q, state_d;
    logic [7:0] steps_q, steps_d;
    logic [1:0] clr_q, clr_d;
    logic       done_q, done_d;
    logic       por_q;
    logic       bp_hit;
    logic       leave_break;
    logic       cmd_acc;
    logic       in_exec;

    assign in_exec   = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign cmd_ready = (state_q != ST_CLEAR);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign cpu_run   = in_exec && !bp_hit;
    // Held high for the first cycle out of reset as well as throughout CLEAR.
    assign cpu_reset = por_q || (state_q == ST_CLEAR);
    assign state     = state_q;
    assign done      = done_q;

`ifdef OVERTURE_RUN_CTRL_BREAKPOINT_EN
    logic skip_q;

    assign bp_hit = bp_en && (cpu_pc == bp_addr) && !skip_q;

    // Lets the CPU execute the breakpoint instruction once after resuming.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            skip_q <= 1'b0;
        else if (state_q == ST_CLEAR)
            skip_q <= 1'b0;
        else if (leave_break)
            skip_q <= 1'b1;
        else if (cpu_run)
            skip_q <= 1'b0;
    end
`else
    logic unused_bp;

    assign bp_hit    = 1'b0;
    assign unused_bp = ^{bp_en, bp_addr, cpu_pc, leave_break};
`endif

    // Priority: accepted command, then breakpoint, then step completion.
    // No-op commands (RUN while running, STEP 0) do not pre-empt the others.
    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        clr_d       = clr_q;
        done_d      = 1'b0;
        leave_break = 1'b0;
        if (state_q == ST_CLEAR) begin
            if (clr_q == 2'(CLEAR_CYCLES - 1)) begin
                state_d = ST_IDLE;
                clr_d   = '0;
            end else begin
                clr_d = clr_q + 2'd1;
            end
        end else if (cmd_acc && (cmd_op == OP_HALT)) begin
            state_d = ST_IDLE;
            steps_d = '0;
        end else if (cmd_acc && (cmd_op == OP_CLEAR)) begin
            state_d = ST_CLEAR;
            steps_d = '0;
            clr_d   = '0;
        end else if (cmd_acc && (cmd_op == OP_RUN) && (state_q != ST_RUN)) begin
            state_d     = ST_RUN;
            leave_break = (state_q == ST_BREAK);
        end else if (cmd_acc && (cmd_op == OP_STEP) && (cmd_arg != 8'd0)) begin
            state_d     = ST_STEP;
            steps_d     = cmd_arg;
            leave_break = (state_q == ST_BREAK);
        end else if (in_exec && bp_hit) begin
            state_d = ST_BREAK;
            done_d  = 1'b1;
        end else if ((state_q == ST_STEP) && cpu_run) begin
            steps_d = steps_q - 8'd1;
            if (steps_q == 8'd1) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            steps_q <= '0;
            clr_q   <= '0;
            done_q  <= 1'b0;
            por_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            por_q   <= 1'b0;
        end
    end

    overture_sat_counter #(
        .WIDTH(CNT_W)
    ) u_cycle_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (cpu_run),
        .clr    (state_q == ST_CLEAR),
        .count  (cycle_count)
    );

endmodule

// File: tb/tb_overture_run_ctrl.sv
// Self-checking bench for overture_run_ctrl: directed scenarios plus random
// commands, compared each cycle against a behavioural model.
module tb_overture_run_ctrl;

`ifdef OVERTURE_RUN_CTRL_BREAKPOINT_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_arg = 8'd0;
    logic       bp_en = 1'b0;
    logic [7:0] bp_addr = 8'd0;
    logic [7:0] cpu_pc = 8'd0;

    logic        cmd_ready, cpu_run, cpu_reset, done;
    logic [2:0]  state;
    logic [15:0] cycle_count;
    logic        cmd_ready4, cpu_run4, cpu_reset4, done4;
    logic [2:0]  state4;
    logic [3:0]  cycle_count4;

    int checks = 0;
    int errors = 0;

    // Behavioural model state (plain integers, states numbered as in the spec)
    int m_state, m_steps, m_clrleft, m_count;
    bit m_skip, m_done, m_por;
    int obs_runs, obs_done;
    bit pc_auto = 1'b0;

    always #5 clk = ~clk;

    overture_run_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_pc(cpu_pc), .cpu_run(cpu_run), .cpu_reset(cpu_reset), .state(state),
        .done(done), .cycle_count(cycle_count)
    );

    overture_run_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_pc(cpu_pc), .cpu_run(cpu_run4), .cpu_reset(cpu_reset4), .state(state4),
        .done(done4), .cycle_count(cycle_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model over one clock edge using the spec's priority rules.
    task automatic model_edge(input bit bp, input bit run_e);
        bit acc;
        acc    = cmd_valid && (m_state != 4);
        m_done = 1'b0;
        m_por  = 1'b0;
        if (m_state == 4) begin
            m_count = 0;
            m_skip  = 1'b0;
            m_clrleft--;
            if (m_clrleft == 0) m_state = 0;
            return;
        end
        if (run_e) begin
            m_count++;
            m_skip = 1'b0;
        end
        if (acc && cmd_op == 2'b00) begin
            m_state = 0; m_steps = 0;
        end else if (acc && cmd_op == 2'b11) begin
            m_state = 4; m_clrleft = 2; m_steps = 0;
        end else if (acc && cmd_op == 2'b01 && m_state != 1) begin
            if (m_state == 3) m_skip = 1'b1;
            m_state = 1;
        end else if (acc && cmd_op == 2'b10 && cmd_arg != 0) begin
            if (m_state == 3) m_skip = 1'b1;
            m_state = 2; m_steps = int'(cmd_arg);
        end else if (bp && (m_state == 1 || m_state == 2)) begin
            m_state = 3; m_done = 1'b1;
        end else if (m_state == 2 && run_e) begin
            m_steps--;
            if (m_steps == 0) begin
                m_state = 0; m_done = 1'b1;
            end
        end
    endtask

    task automatic tick();
        bit bp, run_e;
        int c16, c4;
        @(negedge clk);
        bp    = BP_ON && bp_en && (cpu_pc == bp_addr) && !m_skip;
        run_e = (m_state == 1 || m_state == 2) && !bp;
        c16   = (m_count > 65535) ? 65535 : m_count;
        c4    = (m_count > 15) ? 15 : m_count;
        if (cpu_run === 1'b1) obs_runs++;
        if (done === 1'b1) obs_done++;
        chk("state", 32'(state), 32'(m_state));
        chk("cpu_run", 32'(cpu_run), 32'(run_e));
        chk("cpu_reset", 32'(cpu_reset), 32'(m_por || m_state == 4));
        chk("cmd_ready", 32'(cmd_ready), 32'(m_state != 4));
        chk("done", 32'(done), 32'(m_done));
        chk("cycle_count", 32'(cycle_count), 32'(c16));
        chk("state_w4", 32'(state4), 32'(m_state));
        chk("cpu_run_w4", 32'(cpu_run4), 32'(run_e));
        chk("cpu_reset_w4", 32'(cpu_reset4), 32'(m_por || m_state == 4));
        chk("cmd_ready_w4", 32'(cmd_ready4), 32'(m_state != 4));
        chk("done_w4", 32'(done4), 32'(m_done));
        chk("cycle_count_w4", 32'(cycle_count4), 32'(c4));
        model_edge(bp, run_e);
        @(posedge clk);
        #1;
        if (pc_auto && run_e) cpu_pc = cpu_pc + 8'd1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cpu_run", 32'(cpu_run), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cycle_count", 32'(cycle_count), 32'd0);
        m_state = 0; m_steps = 0; m_clrleft = 0; m_count = 0;
        m_skip = 1'b0; m_done = 1'b0; m_por = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0] exp_brk;
        logic [1:0] rop;
        logic [7:0] rarg;

        // Reset and the one-cycle cpu_reset tail
        #2;
        apply_reset();
        tick();
        tick();

        // STEP 3 from IDLE
        obs_runs = 0;
        obs_done = 0;
        cmd(2'b10, 8'd3);
        repeat (5) tick();
        chk("step3_runs", 32'(obs_runs), 32'd3);
        chk("step3_done_pulses", 32'(obs_done), 32'd1);
        chk("step3_count", 32'(cycle_count), 32'd3);

        // Breakpoint at pc 5 while running, then resume past it
        cpu_pc  = 8'd0;
        bp_addr = 8'd5;
        bp_en   = 1'b1;
        pc_auto = 1'b1;
        cmd(2'b01, 8'd0);
        for (int i = 0; i < 20 && state !== 3'd3; i++) tick();
        exp_brk = BP_ON ? 3'd3 : 3'd1;
        chk("bp_state", 32'(state), 32'(exp_brk));
        cmd(2'b01, 8'd0);
        repeat (3) tick();
        chk("resume_pc_past_bp", 32'(cpu_pc > 8'd5), 32'd1);
        chk("resume_state", 32'(state), 32'd1);
        pc_auto = 1'b0;
        bp_en   = 1'b0;
        cmd(2'b00, 8'd0);
        tick();

        // RUN, HALT, CLEAR back to back
        cmd(2'b01, 8'd0);
        cmd(2'b00, 8'd0);
        cmd(2'b11, 8'd0);
        tick();
        tick();
        tick();
        chk("clear_count", 32'(cycle_count), 32'd0);
        chk("clear_state", 32'(state), 32'd0);

        // Saturation of the 4-bit instance
        cmd(2'b01, 8'd0);
        repeat (20) tick();
        chk("sat_count_w4", 32'(cycle_count4), 32'd15);
        cmd(2'b00, 8'd0);
        tick();

        // STEP 0 is a no-op; reset mid-STEP kills cpu_run immediately
        obs_runs = 0;
        obs_done = 0;
        cmd(2'b10, 8'd0);
        repeat (3) tick();
        chk("step0_runs", 32'(obs_runs), 32'd0);
        chk("step0_done", 32'(obs_done), 32'd0);
        cmd(2'b10, 8'd5);
        tick();
        chk("pre_rst_run", 32'(cpu_run), 32'd1);
        apply_reset();
        tick();

        // Random command traffic
        bp_addr = 8'd3;
        for (int i = 0; i < 400; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rarg = 8'($urandom_range(0, 4));
            if (rop == 2'b10 && rarg == 8'd0 && m_state != 0 && m_state != 3)
                rarg = 8'd2;
            cmd_valid = ($urandom_range(0, 3) == 0) && !(rop == 2'b01 && m_state == 1);
            if (rop == 2'b11 && $urandom_range(0, 3) != 0) cmd_valid = 1'b0;
            cmd_op  = rop;
            cmd_arg = rarg;
            bp_en   = 1'($urandom_range(0, 1));
            cpu_pc  = 8'($urandom_range(0, 7));
            tick();
        end
        cmd_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/overture_run_ctrl.md
OVERTURE_RUN_CTRL -- requirements
Module: overture_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the executed-cycle counter.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state changes on rising edge
  reset_n  in  1  asynchronous, active-low reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
  cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 CLEAR
  cmd_arg  in  8  step count for STEP; ignored otherwise
  bp_en  in  1  breakpoint enable
  bp_addr  in  8  breakpoint PC
  cpu_pc  in  8  CPU program counter
  cpu_run  out  1  CPU execute enable for this cycle
  cpu_reset  out  1  synchronous reset to CPU, active-high
  state  out  3  current FSM state encoding
  done  out  1  one-cycle pulse on STEP completion or breakpoint stop
  cycle_count  out  CNT_W  count of cycles with cpu_run=1

Function
REQ-003 SHALL implement FSM states IDLE=0, RUN=1, STEP=2, BREAK=3, CLEAR=4.
REQ-004 cpu_run SHALL be combinational: 1 iff state is RUN or STEP and bp_hit=0.
REQ-005 bp_hit SHALL be bp_en & (cpu_pc==bp_addr) & ~skip, where skip is a flag set when leaving BREAK via RUN/STEP and cleared after the first cycle with cpu_run=1.
REQ-006 cmd_ready SHALL be 1 in every state except CLEAR.
REQ-007 An accepted command SHALL take effect on the next edge; the acceptance cycle keeps current-state behaviour.
REQ-008 HALT: any state except CLEAR -> IDLE; steps_left cleared.
REQ-009 RUN: -> RUN from IDLE, STEP or BREAK; RUN in RUN is a no-op.
REQ-010 STEP with cmd_arg=N>0: steps_left<=N, -> STEP; restarts count if already in STEP.
REQ-011 STEP with cmd_arg=0: accepted, no state change, no done pulse.
REQ-012 In STEP, each cycle with cpu_run=1 SHALL decrement steps_left; when steps_left==1 and cpu_run=1, -> IDLE and done=1 next cycle.
REQ-013 In RUN or STEP with bp_hit=1: -> BREAK, done=1 next cycle, steps_left preserved.
REQ-014 CLEAR: -> CLEAR, cpu_reset=1 for exactly 2 cycles, cycle_count<=0, skip<=0, then -> IDLE.
REQ-015 Priority on the same edge: accepted command > breakpoint > step completion.
REQ-016 cycle_count SHALL increment by 1 per cpu_run=1 cycle and saturate at all-ones; never wraps.
REQ-017 cpu_reset SHALL be 0 outside CLEAR.

Reset
REQ-018 reset_n=0 SHALL asynchronously force state=IDLE, steps_left=0, skip=0, done=0, cycle_count=0, cpu_reset=1.
REQ-019 cpu_reset SHALL stay 1 for the first cycle after reset_n deasserts, then 0.
REQ-020 Reset mid-RUN/STEP SHALL drop cpu_run to 0 immediately (combinational via state).

Configuration
REQ-021 Macro OVERTURE_RUN_CTRL_BREAKPOINT_EN defined: breakpoint logic per REQ-005/013.
REQ-022 Macro undefined: bp_hit tied 0, BREAK unreachable, bp_en/bp_addr ports retained but ignored, skip flag omitted.

Structure
REQ-023 overture_pkg SHALL hold the state enum, cmd_op encodings and CLEAR_CYCLES=2.
REQ-024 One sub-module overture_sat_counter (parameterised width, enable, sync clear, saturating) SHALL implement cycle_count.

Verification
REQ-025 Reset release -> state=0, cpu_reset=1 for one cycle, cycle_count=0.
REQ-026 STEP arg=3 from IDLE -> cpu_run=1 for exactly 3 cycles, done pulse, state=IDLE, cycle_count=3.
REQ-027 RUN with bp_en=1, bp_addr=5, cpu_pc counting 0..5 -> cpu_run=0 when pc=5, state=BREAK, done=1; then RUN -> one cycle runs at pc=5, continues.
REQ-028 RUN then HALT and CLEAR in back-to-back cycles -> IDLE, then cpu_reset=1 for 2 cycles, cmd_ready=0 during CLEAR, cycle_count=0.
REQ-029 CNT_W=4, RUN 20 cycles -> cycle_count holds 15.
REQ-030 STEP arg=0 in IDLE -> no cpu_run, no done; reset_n low mid-STEP -> cpu_run=0 same cycle.
